// File: rtl/inv_shift_sub_bytes.sv
// AES-128 decryption round stage: InvShiftRows followed by InvSubBytes on one
// 128-bit state, evaluated COLS_PER_CYCLE output columns per busy cycle.
module inv_shift_sub_bytes #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("inv_shift_sub_bytes: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return INV_SBOX[2047 - 8 * int'(a) -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q;
  logic [1:0]     col_q;
  logic           rdy_arm_q;
  logic [127:0]   blk_q;
  logic [127:0]   out_q;
  logic [127:0]   out_d;
  logic           last_col;
  logic           accept;

  assign in_ready  = ((state_q == IDLE) && rdy_arm_q) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;
  assign accept    = in_valid && in_ready;
  assign last_col  = (int'(col_q) + COLS_PER_CYCLE == 4);

  // Column slices: output column c row r takes input column (c - r) mod 4.
  always_comb begin : p_slice
    int c;
    int s;
    c     = 0;
    s     = 0;
    out_d = out_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      c = (int'(col_q) + j) % 4;
      for (int r = 0; r < 4; r++) begin
        s = (c - r + 4) % 4;
        out_d[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(blk_q[127 - 8 * (r + 4 * s) -: 8]);
      end
    end
  end

  // Captured block is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (accept) blk_q <= in_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= 2'd0;
      out_q     <= '0;
      rdy_arm_q <= 1'b0;
    end else begin
      rdy_arm_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            col_q   <= 2'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          out_q <= out_d;
          col_q <= col_q + 2'(COLS_PER_CYCLE);
          if (last_col) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              col_q   <= 2'd0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_shift_sub_bytes.sv
// Bench for inv_shift_sub_bytes: three instances (1, 2 and 4 columns per cycle)
// checked by a scoreboard against an S-box derived from GF(2^8) arithmetic.
module tb_inv_shift_sub_bytes;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_shift_sub_bytes #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  localparam logic [127:0] C1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] ALL63  = {16{8'h63}};
  localparam logic [127:0] ALL52  = {16{8'h52}};
  localparam logic [127:0] SEQ    = 128'h0102030405060708090a0b0c0d0e0f10;

  typedef struct packed {
    logic [127:0] d;
    logic [31:0]  acc;
  } exp_t;

  exp_t         exp_q [3][$];
  bit           seen  [3];
  logic [127:0] last_out [3];
  int           done_cyc [$];
  int           cyc = 0;
  int           n_pass = 0;
  int           n_total = 0;
  logic [7:0]   inv_tab [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: GF(2^8) multiply, forward S-box = affine(inverse), then invert the table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic       hi;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_table();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st);
    logic [7:0] m  [4][4];
    logic [7:0] sh [4][4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) m[i % 4][i / 4] = st[127 - 8 * i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][(c + r) % 4] = m[r][c];
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = inv_tab[sh[i % 4][i / 4]];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard monitor: pushes on accept, pops and compares on output handshake.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    for (int g = 0; g < 3; g++) begin
      lat = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
      if (rst) begin
        exp_q[g].delete();
        seen[g] = 1'b0;
      end else begin
        if (out_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            chk(1'b0, $sformatf("unexpected_out_valid[%0d]", g), out_state[g], '0);
          end else begin
            e = exp_q[g][0];
            if (!seen[g]) begin
              chk(cyc - int'(e.acc) == lat, $sformatf("latency[%0d]", g),
                  128'(cyc - int'(e.acc)), 128'(lat));
              seen[g] = 1'b1;
            end
            if (out_ready[g]) begin
              chk(out_state[g] === e.d, $sformatf("out_state[%0d]", g), out_state[g], e.d);
              last_out[g] = out_state[g];
              void'(exp_q[g].pop_front());
              seen[g] = 1'b0;
              if (g == 0) done_cyc.push_back(cyc);
            end
          end
        end
        if (in_valid[g] && in_ready[g]) begin
          e.d   = model(in_state[g]);
          e.acc = 32'(cyc + 1);
          exp_q[g].push_back(e);
        end
      end
    end
  end

  task automatic send(input int g, input logic [127:0] d);
    bit got;
    got = 1'b0;
    in_valid[g] = 1'b1;
    in_state[g] = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready[g]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, $sformatf("accept_timeout[%0d]", g), '0, 128'd1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_state[g] = rand128();
  endtask

  task automatic drain(input int g);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q[g].size() == 0 && !out_valid[g]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, $sformatf("drain_timeout[%0d]", g), 128'(exp_q[g].size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int k;
    build_table();
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      in_state[g]  = '0;
      out_ready[g] = 1'b1;
      seen[g]      = 1'b0;
      last_out[g]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk(out_valid[g] == 1'b0, "rst_out_valid", 128'(out_valid[g]), '0);
      chk(in_ready[g] == 1'b0, "rst_in_ready", 128'(in_ready[g]), '0);
      chk(out_state[g] == '0, "rst_out_state", out_state[g], '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(in_ready[0] == 1'b0, "in_ready_before_first_edge", 128'(in_ready[0]), '0);
    @(negedge clk);
    chk(in_ready[0] == 1'b1, "in_ready_after_first_edge", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1;

    // Single block and S-box corners
    send(0, C1_IN);  drain(0);
    chk(last_out[0] == C1_OUT, "c1_vector", last_out[0], C1_OUT);
    send(0, ALL63);  drain(0);
    chk(last_out[0] == '0, "all63", last_out[0], '0);
    send(0, '0);     drain(0);
    chk(last_out[0] == ALL52, "all00", last_out[0], ALL52);
    send(0, SEQ);    drain(0);
    chk(last_out[0][127:96] == 32'h09d79ebf, "row_shift", 128'(last_out[0][127:96]), 128'h09d79ebf);

    // Back-pressure, then transfer and accept on the same edge
    out_ready[0] = 1'b0;
    send(0, C1_IN);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        got = 1'b1;
        break;
      end
    end
    chk(got, "bp_wait_valid", 128'(got), 128'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_state[0] = ALL63;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(out_valid[0] == 1'b1, "bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk(out_state[0] == C1_OUT, "bp_out_state", out_state[0], C1_OUT);
      chk(in_ready[0] == 1'b0, "bp_in_ready", 128'(in_ready[0]), '0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk(in_ready[0] == 1'b1, "bp_passthrough_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    drain(0);
    chk(last_out[0] == '0, "bp_second_block", last_out[0], '0);

    // Reset two cycles after accept
    send(0, C1_IN);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(out_valid[0] == 1'b0, "midrst_out_valid", 128'(out_valid[0]), '0);
    chk(out_state[0] == '0, "midrst_out_state", out_state[0], '0);
    chk(in_ready[0] == 1'b0, "midrst_in_ready", 128'(in_ready[0]), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(0, C1_IN);  drain(0);
    chk(last_out[0] == C1_OUT, "after_rst_c1", last_out[0], C1_OUT);

    // Parameter sweep
    send(1, C1_IN);  drain(1);
    chk(last_out[1] == C1_OUT, "cpc2_c1", last_out[1], C1_OUT);
    send(2, C1_IN);  drain(2);
    chk(last_out[2] == C1_OUT, "cpc4_c1", last_out[2], C1_OUT);

    // Streaming: random blocks, in_valid and out_ready held high
    done_cyc.delete();
    in_valid[0] = 1'b1;
    in_state[0] = rand128();
    k = 0;
    for (int i = 0; i < 200 && k < 8; i++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        k++;
        @(posedge clk);
        #1;
        if (k == 8) in_valid[0] = 1'b0;
        else in_state[0] = rand128();
      end
    end
    in_valid[0] = 1'b0;
    chk(k == 8, "stream_accepts", 128'(k), 128'd8);
    drain(0);
    chk(done_cyc.size() == 8, "stream_count", 128'(done_cyc.size()), 128'd8);
    for (int i = 1; i < done_cyc.size(); i++)
      chk(done_cyc[i] - done_cyc[i-1] == 5, "stream_interval",
          128'(done_cyc[i] - done_cyc[i-1]), 128'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
